apb_mem_slave: RTL and testbench
================================

# apb_mem_slave

Parametrised APB4 memory-mapped slave: the next generation of the team's 256×32 APB memory slave, generalised in data width, depth and address width, with byte strobes, programmable wait states and error response. Sits behind the APB bridge/decoder as a scratch-RAM or register-file target; one PSEL per instance.

## Interface

Parameters:
- ADDR_W, 12, PADDR width in bits.
- DATA_W, 32, PWDATA/PRDATA width; legal values 8, 16, 32, 64.
- DEPTH, 256, number of DATA_W-bit words; must satisfy DEPTH ≤ 2^(ADDR_W − BOFF), where BOFF = log2(DATA_W/8).
- WAIT_STATES, 0, access cycles with PREADY low before completion (0–15).

Ports:
- PCLK  in  1  single clock; all logic on its rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_W  byte address.
- PWDATA  in  DATA_W  write data.
- PSTRB  in  DATA_W/8  byte-lane write enables (ignored on reads).
- PRDATA  out  DATA_W  read data, registered.
- PREADY  out  1  transfer completion, registered.
- PSLVERR  out  1  error response, registered.

## Operation

- Word index IDX = PADDR[ADDR_W−1:BOFF]; byte offset OFS = PADDR[BOFF−1:0] (no offset when DATA_W = 8).
- Error condition ERR = (IDX ≥ DEPTH) or (OFS ≠ 0). Computed from the PADDR captured in the setup cycle.
- FSM states: IDLE, ACCESS.
  - IDLE: on PSEL=1 ∧ PENABLE=0 (setup cycle) → ACCESS; capture PADDR, PWRITE, PWDATA, PSTRB; load wait counter with WAIT_STATES.
  - ACCESS, counter > 0: decrement; stay.
  - ACCESS, counter = 0 and PREADY=1 (completion cycle): → IDLE.
  - ACCESS with PSEL=0 (master abort, protocol violation): → IDLE, no write, outputs cleared next edge.
- PREADY is registered high exactly for the one completion cycle; it is set at the edge where the counter is at 0 (or at the setup edge when WAIT_STATES = 0).
- Write: on the completion edge, if ¬ERR, mem[IDX] byte lane b ← PWDATA lane b for each PSTRB[b]=1; other lanes unchanged. PSTRB = 0 is a legal no-op write.
- Read: PRDATA loaded with mem[IDX] at the edge that raises PREADY; PRDATA = 0 in every other cycle and when ERR.
- PSLVERR = ERR during the completion cycle only, 0 otherwise. An erroring write changes no memory.
- Memory contents are not cleared by reset.

## Timing

- Reset: PREADY=0, PSLVERR=0, PRDATA=0, state IDLE, counter 0. Reset mid-transfer aborts it; no write commits even if the same edge would have completed.
- Setup cycle T0, first access cycle T1. Completion cycle = T1 + WAIT_STATES; total transfer = WAIT_STATES + 2 cycles.
- Back-to-back: a new setup cycle is accepted in the cycle immediately after completion (state is IDLE then). No idle cycle required.
- Write-then-read to the same IDX back-to-back returns the new data (write commits at the completion edge; the read samples memory at least one edge later).
- PENABLE=1 seen in IDLE without a preceding setup cycle is ignored.

## Test plan

- Reset: assert PRESET 2 cycles during a pending access → PREADY/PSLVERR/PRDATA all 0, no write committed (later read of that address returns pre-reset value).
- DATA_W=32, WAIT_STATES=0: write 0xDEADBEEF to 0x010 with PSTRB=0xF, then read 0x010 → PREADY high in T1 of each transfer, PRDATA=0xDEADBEEF, PSLVERR=0.
- Partial write: after above, write 0x11223344 to 0x010 with PSTRB=0x5 → read returns 0xDE22BE44.
- WAIT_STATES=3: read 0x004 → PREADY low for 3 access cycles, high in the 4th (cycle T4); PRDATA valid only in that cycle.
- Errors, DEPTH=256: write to 0x400 (IDX=256) and to 0x011 (misaligned) → PSLVERR=1 in completion cycle, PRDATA=0, memory at 0x000 and 0x010 unchanged.
- Back-to-back write 0xA5A5A5A5 to 0x020 then immediate read of 0x020 with no idle cycle → read returns 0xA5A5A5A5; abort (PSEL dropped in ACCESS) → no write, FSM back to IDLE.

Source files
------------

// File: rtl/apb_mem_slave.sv
// APB4 memory-mapped slave: DEPTH x DATA_W scratch RAM with byte strobes,
// a fixed number of wait states and an error response for bad addresses.
module apb_mem_slave #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W/8-1:0] PSTRB,
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR
);

  localparam int NB    = DATA_W / 8;
  localparam int BOFF  = $clog2(NB);
  localparam int IDX_W = ADDR_W - BOFF;
  localparam int MAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'((1 << BOFF) - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  // Out-of-range word index or a non-zero byte offset within the word.
  function automatic logic addr_err(input logic [ADDR_W-1:0] a);
    logic [IDX_W-1:0] idx;
    idx = IDX_W'(a >> BOFF);
    return ({1'b0, idx} >= (IDX_W + 1)'(DEPTH)) || ((a & OFS_MASK) != '0);
  endfunction

  function automatic logic [MAW-1:0] mem_idx(input logic [ADDR_W-1:0] a);
    return MAW'(a >> BOFF);
  endfunction

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]       strb_q, strb_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;

  logic                raise;
  logic [ADDR_W-1:0]   rd_addr;
  logic                rd_write;
  logic                rd_en;
  logic                wr_en;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    raise     = 1'b0;
    rd_addr   = addr_q;
    rd_write  = write_q;
    rd_en     = 1'b0;
    wr_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ACCESS;
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
          strb_d  = PSTRB;
          cnt_d   = 4'(WAIT_STATES);
          // Without wait states the response is launched at the setup edge,
          // so the live bus values are used rather than the captured ones.
          if (WAIT_STATES == 0) begin
            raise    = 1'b1;
            rd_addr  = PADDR;
            rd_write = PWRITE;
          end
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (pready_q) begin
          state_d = IDLE;
          wr_en   = write_q && !addr_err(addr_q);
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            raise = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (raise) begin
      pready_d  = 1'b1;
      pslverr_d = addr_err(rd_addr);
      rd_en     = !rd_write && !addr_err(rd_addr);
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  // One byte-wide RAM per lane keeps strobed writes a plain per-lane enable.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge PCLK) begin
      if (!PRESET && wr_en && strb_q[gi]) begin
        mem[mem_idx(addr_q)] <= wdata_q[gi*8 +: 8];
      end
    end

    always_ff @(posedge PCLK) begin
      if (PRESET || !rd_en) begin
        rd_q <= 8'd0;
      end else begin
        rd_q <= mem[mem_idx(rd_addr)];
      end
    end

    assign PRDATA[gi*8 +: 8] = rd_q;
  end

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: a zero-wait and a three-wait instance
// share one APB bus, each with its own PSEL.
module tb_apb_mem_slave;

  logic        clk = 1'b0;
  logic        preset, penable, pwrite, psel0, psel3;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3, pslverr0, pslverr3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_mem_slave #(.ADDR_W(12), .DATA_W(32), .DEPTH(256), .WAIT_STATES(0)) dut0 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
  );

  apb_mem_slave #(.ADDR_W(12), .DATA_W(32), .DEPTH(256), .WAIT_STATES(3)) dut3 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3)
  );

  typedef struct {
    bit          s3;
    bit          wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs [25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sample(input bit s3, output logic rdy, output logic er, output logic [31:0] rd);
    rdy = s3 ? pready3  : pready0;
    er  = s3 ? pslverr3 : pslverr0;
    rd  = s3 ? prdata3  : prdata0;
  endtask

  task automatic setup(input bit s3, input bit wr, input logic [11:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    @(posedge clk) #1;
    psel0   = !s3;
    psel3   = s3;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
    pstrb   = s;
  endtask

  task automatic idle();
    @(posedge clk) #1;
    psel0   = 1'b0;
    psel3   = 1'b0;
    penable = 1'b0;
  endtask

  // Full transfer; returns in the completion cycle so the next setup follows directly.
  task automatic xfer(input vec_t v, input string tag);
    int nw;
    logic rdy, er;
    logic [31:0] rd;
    nw = v.s3 ? 3 : 0;
    setup(v.s3, v.wr, v.addr, v.wdata, v.strb);
    @(posedge clk) #1;
    penable = 1'b1;
    for (int i = 0; i <= nw; i++) begin
      @(negedge clk);
      sample(v.s3, rdy, er, rd);
      if (i < nw) begin
        chk({tag, " wait_pready"}, 32'(rdy), 32'd0);
        chk({tag, " wait_prdata"}, rd, 32'd0);
        @(posedge clk) #1;
      end else begin
        chk({tag, " pready"}, 32'(rdy), 32'd1);
        chk({tag, " pslverr"}, 32'(er), 32'(v.exp_err));
        chk({tag, " prdata"}, rd, v.exp_rd);
      end
    end
    $display("%s: %s dut%0d addr=%h wdata=%h strb=%h -> prdata=%h pslverr=%0d",
             tag, v.wr ? "WR" : "RD", v.s3 ? 3 : 0, v.addr, v.wdata, v.strb, rd, er);
  endtask

  task automatic reset_mid(input bit s3, input logic [11:0] a, input int pre, input string tag);
    logic rdy, er;
    logic [31:0] rd;
    setup(s3, 1'b1, a, 32'hFFFF_FFFF, 4'hF);
    @(posedge clk) #1;
    penable = 1'b1;
    repeat (pre) @(posedge clk) #1;
    preset = 1'b1;
    @(posedge clk) #1;
    @(negedge clk);
    sample(s3, rdy, er, rd);
    chk({tag, " rst_pready"}, 32'(rdy), 32'd0);
    chk({tag, " rst_pslverr"}, 32'(er), 32'd0);
    chk({tag, " rst_prdata"}, rd, 32'd0);
    $display("%s: reset during write to %h -> pready=%0d pslverr=%0d prdata=%h", tag, a, rdy, er, rd);
    @(posedge clk) #1;
    preset  = 1'b0;
    psel0   = 1'b0;
    psel3   = 1'b0;
    penable = 1'b0;
  endtask

  initial begin
    vec_t v;

    vecs[0]  = '{0, 1, 12'h010, 32'hDEADBEEF, 4'hF, 32'h0,        0};
    vecs[1]  = '{0, 0, 12'h010, 32'h0,        4'h0, 32'hDEADBEEF, 0};
    vecs[2]  = '{0, 1, 12'h010, 32'h11223344, 4'h5, 32'h0,        0};
    vecs[3]  = '{0, 0, 12'h010, 32'h0,        4'h0, 32'hDE22BE44, 0};
    vecs[4]  = '{0, 1, 12'h000, 32'hCAFEF00D, 4'hF, 32'h0,        0};
    vecs[5]  = '{0, 1, 12'h400, 32'hFFFFFFFF, 4'hF, 32'h0,        1};
    vecs[6]  = '{0, 1, 12'h011, 32'hFFFFFFFF, 4'hF, 32'h0,        1};
    vecs[7]  = '{0, 0, 12'h000, 32'h0,        4'h0, 32'hCAFEF00D, 0};
    vecs[8]  = '{0, 0, 12'h010, 32'h0,        4'h0, 32'hDE22BE44, 0};
    vecs[9]  = '{0, 0, 12'h011, 32'h0,        4'h0, 32'h0,        1};
    vecs[10] = '{0, 0, 12'h400, 32'h0,        4'h0, 32'h0,        1};
    vecs[11] = '{0, 1, 12'h3FC, 32'h01020304, 4'hF, 32'h0,        0};
    vecs[12] = '{0, 1, 12'h3FC, 32'hFFFFFFFF, 4'h0, 32'h0,        0};
    vecs[13] = '{0, 0, 12'h3FC, 32'h0,        4'h0, 32'h01020304, 0};
    vecs[14] = '{0, 1, 12'h010, 32'h99887766, 4'hA, 32'h0,        0};
    vecs[15] = '{0, 0, 12'h010, 32'h0,        4'h0, 32'h99227744, 0};
    vecs[16] = '{0, 1, 12'h020, 32'hA5A5A5A5, 4'hF, 32'h0,        0};
    vecs[17] = '{0, 0, 12'h020, 32'h0,        4'h0, 32'hA5A5A5A5, 0};
    vecs[18] = '{0, 1, 12'h030, 32'h12345678, 4'hF, 32'h0,        0};
    vecs[19] = '{1, 1, 12'h004, 32'h55AA55AA, 4'hF, 32'h0,        0};
    vecs[20] = '{1, 0, 12'h004, 32'h0,        4'h0, 32'h55AA55AA, 0};
    vecs[21] = '{1, 0, 12'h402, 32'h0,        4'h0, 32'h0,        1};
    vecs[22] = '{1, 1, 12'h008, 32'h0BADF00D, 4'hF, 32'h0,        0};
    vecs[23] = '{1, 0, 12'h008, 32'h0,        4'h0, 32'h0BADF00D, 0};
    vecs[24] = '{1, 1, 12'h404, 32'hFFFFFFFF, 4'hF, 32'h0,        1};

    preset  = 1'b1;
    psel0   = 1'b0;
    psel3   = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset pready0", 32'(pready0), 32'd0);
    chk("reset pslverr0", 32'(pslverr0), 32'd0);
    chk("reset prdata0", prdata0, 32'd0);
    chk("reset pready3", 32'(pready3), 32'd0);
    chk("reset pslverr3", 32'(pslverr3), 32'd0);
    chk("reset prdata3", prdata3, 32'd0);
    $display("reset: pready=%0d/%0d pslverr=%0d/%0d prdata=%h/%h",
             pready0, pready3, pslverr0, pslverr3, prdata0, prdata3);
    @(posedge clk) #1;
    preset = 1'b0;

    for (int i = 0; i < 25; i++) begin
      xfer(vecs[i], $sformatf("vec%0d", i));
    end
    idle();

    // Abort in the wait phase of the slow instance: no response, no write.
    setup(1, 1'b1, 12'h004, 32'h0, 4'hF);
    @(posedge clk) #1;
    psel3 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("abort3 pready c%0d", i), 32'(pready3), 32'd0);
    end
    $display("abort3: write to 004 dropped in access phase");
    v = '{1, 0, 12'h004, 32'h0, 4'h0, 32'h55AA55AA, 0};
    xfer(v, "abort3_rd");
    idle();

    // Abort in the completion cycle of the fast instance.
    setup(0, 1'b1, 12'h020, 32'h0, 4'hF);
    @(posedge clk) #1;
    psel0 = 1'b0;
    @(posedge clk) #1;
    @(negedge clk);
    chk("abort0 pready", 32'(pready0), 32'd0);
    $display("abort0: write to 020 dropped in completion cycle");
    v = '{0, 0, 12'h020, 32'h0, 4'h0, 32'hA5A5A5A5, 0};
    xfer(v, "abort0_rd");
    idle();

    // PENABLE high in IDLE without a setup cycle.
    @(posedge clk) #1;
    psel0   = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b0;
    paddr   = 12'h010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("noset pready c%0d", i), 32'(pready0), 32'd0);
      chk($sformatf("noset prdata c%0d", i), prdata0, 32'd0);
    end
    $display("noset: PENABLE without setup ignored, pready=%0d", pready0);
    idle();

    reset_mid(0, 12'h030, 0, "rst0");
    v = '{0, 0, 12'h030, 32'h0, 4'h0, 32'h12345678, 0};
    xfer(v, "rst0_rd");
    idle();

    reset_mid(1, 12'h008, 2, "rst3");
    v = '{1, 0, 12'h008, 32'h0, 4'h0, 32'h0BADF00D, 0};
    xfer(v, "rst3_rd");
    idle();

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
